vend_ctrl: RTL



---
 rtl/vend_pkg.sv | 16 +
 rtl/vend_if.sv | 29 ++
 rtl/vend_settle_timer.sv | 27 ++
 rtl/vend_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: shared state codes, beep codes and widths for the vending controller
package vend_pkg;
    localparam int ST_W = 3;
    localparam logic [ST_W-1:0] S_IDLE   = 3'd0;
    localparam logic [ST_W-1:0] S_CREDIT = 3'd1;
    localparam logic [ST_W-1:0] S_VEND   = 3'd2;
    localparam logic [ST_W-1:0] S_REFUND = 3'd3;
    localparam logic [ST_W-1:0] S_HOLD   = 3'd4;
    typedef enum logic [2:0] {
        BEEP_NONE   = 3'd0,
        BEEP_COIN   = 3'd1,
        BEEP_OK     = 3'd2,
        BEEP_REFUND = 3'd3,
        BEEP_REJECT = 3'd4
    } beep_e;
endpackage

// File: rtl/vend_if.sv
// vend_if: pulse inputs from the decoders and display/effect outputs of the controller
interface vend_if import vend_pkg::*; #(
    parameter int N_COIN = 3,
    parameter int SW     = 2,
    parameter int CW     = 8
) ();
    logic [N_COIN-1:0] coin;
    logic              sel_next;
    logic              sel_prev;
    logic              cancel;
    logic              restock;
    logic [SW-1:0]     sel;
    logic [CW-1:0]     price;
    logic [CW-1:0]     credit;
    logic [CW-1:0]     change;
    logic              sold_out;
    logic [ST_W-1:0]   state_o;
    logic              vend;
    logic [2:0]        beep_code;
    logic              busy;
    modport master (
        output coin, sel_next, sel_prev, cancel, restock,
        input  sel, price, credit, change, sold_out, state_o, vend, beep_code, busy
    );
    modport slave (
        input  coin, sel_next, sel_prev, cancel, restock,
        output sel, price, credit, change, sold_out, state_o, vend, beep_code, busy
    );
endinterface

// File: rtl/vend_settle_timer.sv
// vend_settle_timer: loadable down-counter whose done pulse closes the HOLD window
module vend_settle_timer #(
    parameter int SETTLE_CYC = 100_000_000
) (
    input  logic clk,
    input  logic rstn,
    input  logic load,
    output logic done
);
    localparam int W = $clog2(SETTLE_CYC);
    logic [W-1:0] cnt;
    logic         run;
    // load SETTLE_CYC-1 so that the window spans exactly SETTLE_CYC cycles
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (load) begin
            cnt <= W'(SETTLE_CYC - 1);
            run <= 1'b1;
        end else if (run) begin
            if (cnt == '0) run <= 1'b0;
            else cnt <= cnt - 1'b1;
        end
    end
    assign done = run && cnt == '0;
endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: vending transaction FSM with per-item stock, credit saturation and settle hold
module vend_ctrl import vend_pkg::*; #(
    parameter int                     N_ITEM     = 4,
    parameter int                     N_COIN     = 3,
    parameter int                     CW         = 8,
    parameter logic [N_ITEM*CW-1:0]   PRICE_VEC  = {8'd30, 8'd24, 8'd15, 8'd5},
    parameter logic [N_COIN*CW-1:0]   COIN_VEC   = {8'd10, 8'd5, 8'd1},
    parameter int                     CREDIT_MAX = 199,
    parameter int                     STOCK_W    = 4,
    parameter int                     STOCK_INIT = 3,
    parameter int                     SETTLE_CYC = 100_000_000,
    parameter int                     SEL_REFUND = 1
) (
    input  logic clk,
    input  logic rstn,
    vend_if.slave bus
);
    localparam int SW = $clog2(N_ITEM);
    logic [ST_W-1:0]    st;
    logic [SW-1:0]      sel;
    logic [CW-1:0]      price;
    logic [CW-1:0]      credit;
    logic [CW-1:0]      change;
    logic [STOCK_W-1:0] stock [N_ITEM];
    logic               vend;
    beep_e              beep;
    logic               sel_moved;
    logic [CW-1:0]      coin_val;
    logic [CW:0]        sum;
    logic               coin_hit, reject, step, sold_out, ready, done;
    logic [SW-1:0]      sel_up, sel_dn;

    // highest-index coin wins when several pulse together
    always_comb begin
        coin_val = '0;
        for (int j = 0; j < N_COIN; j++) if (bus.coin[j]) coin_val = COIN_VEC[j*CW +: CW];
    end

    assign coin_hit = |bus.coin;
    assign sum      = {1'b0, credit} + {1'b0, coin_val};
    assign reject   = sum > (CW+1)'(CREDIT_MAX);
    assign step     = bus.sel_next | bus.sel_prev;
    assign sel_up   = (sel == SW'(N_ITEM - 1)) ? '0 : sel + 1'b1;
    assign sel_dn   = (sel == '0) ? SW'(N_ITEM - 1) : sel - 1'b1;
    assign sold_out = stock[sel] == '0;
    // price lags sel by a cycle, so a just-moved selection must not be compared yet
    assign ready    = credit >= price && !sold_out && !sel_moved;

    vend_settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_timer (
        .clk  (clk),
        .rstn (rstn),
        .load (st == S_VEND || st == S_REFUND),
        .done (done)
    );

    // transaction FSM and datapath; inputs only act in IDLE/CREDIT with cancel > coin > select
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st        <= S_IDLE;
            sel       <= '0;
            price     <= PRICE_VEC[CW-1:0];
            credit    <= '0;
            change    <= '0;
            vend      <= 1'b0;
            beep      <= BEEP_NONE;
            sel_moved <= 1'b0;
            for (int i = 0; i < N_ITEM; i++) stock[i] <= STOCK_W'(STOCK_INIT);
        end else begin
            price     <= PRICE_VEC[int'(sel)*CW +: CW];
            vend      <= 1'b0;
            beep      <= BEEP_NONE;
            sel_moved <= 1'b0;
            if (st == S_IDLE || st == S_CREDIT) begin
                if (bus.cancel) begin
                    if (st == S_CREDIT) begin
                        change <= credit;
                        beep   <= BEEP_REFUND;
                        st     <= S_REFUND;
                    end
                end else if (coin_hit) begin
                    if (st == S_CREDIT && reject) begin
                        beep <= BEEP_REJECT;
                    end else begin
                        credit <= sum[CW-1:0];
                        beep   <= BEEP_COIN;
                        st     <= S_CREDIT;
                    end
                end else if (step) begin
                    if (st == S_CREDIT && SEL_REFUND != 0) begin
                        change <= credit;
                        beep   <= BEEP_REFUND;
                        st     <= S_REFUND;
                    end else begin
                        sel       <= bus.sel_next ? sel_up : sel_dn;
                        sel_moved <= 1'b1;
                    end
                end else if (st == S_CREDIT && ready) begin
                    change     <= credit - price;
                    vend       <= 1'b1;
                    beep       <= BEEP_OK;
                    stock[sel] <= stock[sel] - 1'b1;
                    st         <= S_VEND;
                end
                if (st == S_IDLE && bus.restock)
                    for (int i = 0; i < N_ITEM; i++) stock[i] <= STOCK_W'(STOCK_INIT);
            end else if (st == S_VEND || st == S_REFUND) begin
                st <= S_HOLD;
            end else if (done) begin
                credit <= '0;
                change <= '0;
                st     <= S_IDLE;
            end
        end
    end

    assign bus.sel       = sel;
    assign bus.price     = price;
    assign bus.credit    = credit;
    assign bus.change    = change;
    assign bus.sold_out  = sold_out;
    assign bus.state_o   = st;
    assign bus.vend      = vend;
    assign bus.beep_code = beep;
    assign bus.busy      = st == S_VEND || st == S_REFUND || st == S_HOLD;
endmodule
